hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage ARM CPU. It drives the enable and bubble/flush inputs of every pipeline register. The front-end registers (PC, IF/ID, ID/EX) are enable-gated flops, and this block is the sole source of their `en` signals. It handles load-use hazards, taken-branch flushes, multi-cycle MUL occupancy of EX and data-memory wait freezes, and keeps saturating stall and flush counters for performance readout.

## Interface
Parameters:
- MUL_LAT, 3: total cycles a MUL occupies EX; legal range 1..15.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_rn, id_rm  in  5  source register numbers of the instruction in ID.
- id_use_rn, id_use_rm  in  1  the ID instruction actually reads Rn / Rm.
- id_is_mul  in  1  the ID instruction is a MUL.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- br_taken  in  1  the branch in ID resolved taken this cycle.
- dmem_wait  in  1  data memory not ready; freeze the whole pipe.
- pc_en, ifid_en, idex_en  out  1  front-end register enables.
- back_en  out  1  shared enable for EX/MEM and MEM/WB.
- ifid_flush  out  1  load a NOP into IF/ID at the next edge.
- idex_bubble  out  1  load a NOP into ID/EX at the next edge.
- exmem_bubble  out  1  load a NOP into EX/MEM at the next edge.
- busy  out  1  FSM is in MUL_HOLD.
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters.

## Operation
- FSM states:
  - RUN.
  - MUL_HOLD, with a 4-bit down-counter `hold`.
- Load-use hazard `lu`: `ex_mem_read & (ex_rd != 31) & ((id_use_rn & id_rn == ex_rd) | (id_use_rm & id_rm == ex_rd))`. Register 31 (XZR) never hazards.
- Outputs are combinational from state and inputs. Priority, highest first:
  1. dmem_wait=1: all enables 0, all bubbles and flush 0. State and `hold` are frozen. stall_cnt increments.
  2. MUL_HOLD: pc_en=ifid_en=idex_en=0, back_en=1, exmem_bubble=1. br_taken and lu are ignored. stall_cnt increments.
  3. lu=1: pc_en=ifid_en=0, idex_en=1, idex_bubble=1, back_en=1. br_taken is ignored; the branch re-resolves next cycle. stall_cnt increments.
  4. br_taken=1: all enables 1, ifid_flush=1. flush_cnt increments.
  5. Otherwise: all enables 1, all bubbles and flush 0.
- Transitions:
  - RUN to MUL_HOLD when priorities 1 and 3 are inactive, id_is_mul=1 and MUL_LAT>1. `hold` loads MUL_LAT-1. id_is_mul with br_taken in the same cycle is still legal: the MUL advances and IF/ID flushes.
  - MUL_HOLD: `hold` decrements each non-frozen cycle. Return to RUN at the edge where `hold` goes 1 to 0.
  - With MUL_LAT=1 the FSM never leaves RUN.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W-1. There is no wrap.
  - Counters are cleared only by reset.
- Reset (reset_n=0, asynchronous):
  - State RUN, `hold`=0, both counters 0, busy=0.
  - All enables, bubbles and flush are forced to 0 while reset_n is low, regardless of other inputs.
  - Reset during MUL_HOLD aborts the hold immediately.
- After the reset_n rising edge, the block behaves as RUN from the first clock edge.

## Timing
- Input to output paths are combinational in the same cycle. Downstream registers sample the outputs at the next rising edge.
- Load-use costs exactly 1 bubble cycle; the dependent instruction advances in the following cycle if no new hazard exists.
- A MUL latched into ID/EX at edge E0 is held for MUL_LAT-1 cycles, then captured into EX/MEM at edge E0+MUL_LAT, plus any dmem_wait cycles.
- A taken branch costs 1 flushed fetch slot.
- busy rises at the edge that enters MUL_HOLD and falls at the edge that returns to RUN.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rn=5, id_use_rn=1 for one cycle → pc_en=0, ifid_en=0, idex_bubble=1, stall_cnt 0→1. Next cycle with ex_mem_read=0 → all enables 1.
- XZR exclusion: ex_mem_read=1, ex_rd=31, id_rm=31, id_use_rm=1 → no stall, stall_cnt unchanged.
- MUL, MUL_LAT=3: id_is_mul=1 in RUN → busy=1 for 2 cycles with exmem_bubble=1 and front enables 0, then RUN. stall_cnt=2.
- MUL plus dmem_wait: dmem_wait=1 in the second MUL_HOLD cycle for 3 cycles → all enables 0 and `hold` frozen. MUL_HOLD exits 1 cycle after dmem_wait drops. stall_cnt=5.
- Branch: br_taken=1 with no hazard → ifid_flush=1 for 1 cycle, flush_cnt 0→1. br_taken=1 together with lu=1 → ifid_flush=0, flush_cnt unchanged.
- Saturation and reset: CNT_W=4, run 20 lu cycles → stall_cnt=15. Assert reset_n=0 mid-MUL_HOLD → immediately busy=0, enables 0, counters 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard/stall
// controller. The datapath (master) reports ID/EX operand information,
// branch resolution and memory readiness. The controller (slave) returns
// the register enables, bubbles, flush and the performance counters.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  // ID stage operand information
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             id_is_mul;
  // EX stage load information
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  // Branch resolution and memory readiness
  logic             br_taken;
  logic             dmem_wait;
  // Pipeline register controls
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             back_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             busy;
  // Performance counters
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rn, id_rm, id_use_rn, id_use_rm, id_is_mul,
    output ex_mem_read, ex_rd, br_taken, dmem_wait,
    input  pc_en, ifid_en, idex_en, back_en,
    input  ifid_flush, idex_bubble, exmem_bubble, busy,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rn, id_rm, id_use_rn, id_use_rm, id_is_mul,
    input  ex_mem_read, ex_rd, br_taken, dmem_wait,
    output pc_en, ifid_en, idex_en, back_en,
    output ifid_flush, idex_bubble, exmem_bubble, busy,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline. Produces the
// enables and bubble/flush controls for every pipeline register from the
// current hazard situation, holds EX for multi-cycle MULs, freezes the
// whole pipe while data memory is busy, and keeps saturating stall/flush
// counters. Outputs are combinational from state and inputs.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hazard_stall_ctrl_if.slave      bus
);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_HOLD = 1'b1
  } state_t;

  localparam logic [3:0]       HOLD_INIT = 4'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [4:0]       XZR       = 5'd31;

  state_t     state_reg, state_next;
  logic [3:0] hold_reg, hold_next;

  logic       lu;
  logic       pc_en, ifid_en, idex_en, back_en;
  logic       ifid_flush, idex_bubble, exmem_bubble;
  logic [1:0] cnt_inc;  // [0] stall, [1] flush

  // Load-use hazard: a load in EX writes a register the ID instruction reads
  always_comb begin
    lu = bus.ex_mem_read && (bus.ex_rd != XZR) &&
         ((bus.id_use_rn && (bus.id_rn == bus.ex_rd)) ||
          (bus.id_use_rm && (bus.id_rm == bus.ex_rd)));
  end

  // State and hold-counter register; reset aborts any MUL hold at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= RUN;
      hold_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  // Prioritised output decode and next-state selection
  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    back_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    cnt_inc      = 2'b00;

    if (!reset_n) begin
      // Every control stays low while reset is asserted.
    end else if (bus.dmem_wait) begin
      // Whole pipe frozen; state and hold keep their values.
      cnt_inc[0] = 1'b1;
    end else if (state_reg == MUL_HOLD) begin
      // MUL keeps EX; the back end drains with a bubble behind it.
      back_en      = 1'b1;
      exmem_bubble = 1'b1;
      cnt_inc[0]   = 1'b1;
      hold_next    = hold_reg - 4'd1;
      if (hold_reg == 4'd1) begin
        state_next = RUN;
      end
    end else if (lu) begin
      // Hold PC and IF/ID one cycle, insert a bubble into ID/EX.
      idex_en     = 1'b1;
      idex_bubble = 1'b1;
      back_en     = 1'b1;
      cnt_inc[0]  = 1'b1;
    end else begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      back_en    = 1'b1;
      ifid_flush = bus.br_taken;
      cnt_inc[1] = bus.br_taken;
      // A single-cycle MUL needs no hold at all.
      if (bus.id_is_mul && (MUL_LAT > 1)) begin
        state_next = MUL_HOLD;
        hold_next  = HOLD_INIT;
      end
    end
  end

  // Saturating performance counters: index 0 counts stalls, 1 flushes
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Count qualifying cycles, sticking at the all-ones value
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.idex_en      = idex_en;
  assign bus.back_en      = back_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_bubble = exmem_bubble;
  assign bus.busy         = (state_reg == MUL_HOLD);
  assign bus.stall_cnt    = g_cnt[0].cnt_reg;
  assign bus.flush_cnt    = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl. Two instances share the same stimulus:
// dut0 (MUL_LAT=3, CNT_W=16) and dut1 (MUL_LAT=1, CNT_W=4). A directed
// vector table covers the documented scenarios, short hand-written
// sequences cover saturation and reset in the middle of a MUL hold, and a
// randomized run is compared against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic [4:0] rn;
    logic [4:0] rm;
    logic       use_rn;
    logic       use_rm;
    logic       mul;
    logic       mrd;
    logic [4:0] rd;
    logic       br;
    logic       dw;
  } in_t;

  typedef struct {
    in_t        i;
    logic [7:0] ctl;    // {pc,ifid,idex,back,flush,idex_bub,exmem_bub,busy}
    int         stall;
    int         flush;
  } vec_t;

  typedef struct {
    int hold;   // remaining MUL hold cycles, 0 = running
    int stall;
    int flush;
  } mdl_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  in_t  drv;

  int n_total = 0;
  int n_bad   = 0;
  mdl_t m0, m1;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus0 ();
  hazard_stall_ctrl_if #(.CNT_W(4))  bus1 ();

  assign bus0.id_rn = drv.rn;        assign bus1.id_rn = drv.rn;
  assign bus0.id_rm = drv.rm;        assign bus1.id_rm = drv.rm;
  assign bus0.id_use_rn = drv.use_rn; assign bus1.id_use_rn = drv.use_rn;
  assign bus0.id_use_rm = drv.use_rm; assign bus1.id_use_rm = drv.use_rm;
  assign bus0.id_is_mul = drv.mul;   assign bus1.id_is_mul = drv.mul;
  assign bus0.ex_mem_read = drv.mrd; assign bus1.ex_mem_read = drv.mrd;
  assign bus0.ex_rd = drv.rd;        assign bus1.ex_rd = drv.rd;
  assign bus0.br_taken = drv.br;     assign bus1.br_taken = drv.br;
  assign bus0.dmem_wait = drv.dw;    assign bus1.dmem_wait = drv.dw;

  hazard_stall_ctrl #(.MUL_LAT(3), .CNT_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  hazard_stall_ctrl #(.MUL_LAT(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ctl0();
    return {bus0.pc_en, bus0.ifid_en, bus0.idex_en, bus0.back_en,
            bus0.ifid_flush, bus0.idex_bubble, bus0.exmem_bubble, bus0.busy};
  endfunction

  function automatic logic [7:0] ctl1();
    return {bus1.pc_en, bus1.ifid_en, bus1.idex_en, bus1.back_en,
            bus1.ifid_flush, bus1.idex_bubble, bus1.exmem_bubble, bus1.busy};
  endfunction

  function automatic in_t mi(int rn, int rm, int urn, int urm, int mul,
                             int mrd, int rd, int br, int dw);
    in_t v;
    v.rn = 5'(rn); v.rm = 5'(rm); v.use_rn = 1'(urn); v.use_rm = 1'(urm);
    v.mul = 1'(mul); v.mrd = 1'(mrd); v.rd = 5'(rd); v.br = 1'(br);
    v.dw = 1'(dw);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: the documented priority rules applied to one cycle.
  function automatic int sat_inc(int v, int cmax);
    return (v < cmax) ? v + 1 : cmax;
  endfunction

  function automatic bit is_lu(in_t v);
    if (!v.mrd || v.rd == 5'd31) return 1'b0;
    return (v.use_rn && v.rn == v.rd) || (v.use_rm && v.rm == v.rd);
  endfunction

  function automatic void predict(input mdl_t m, input in_t v, input int lat,
                                  input int cmax, output logic [7:0] ctl,
                                  output mdl_t n);
    n = m;
    if (v.dw) begin
      ctl = {7'b0, 1'(m.hold > 0)};
      n.stall = sat_inc(m.stall, cmax);
    end else if (m.hold > 0) begin
      ctl = 8'b0001_0011;
      n.hold = m.hold - 1;
      n.stall = sat_inc(m.stall, cmax);
    end else if (is_lu(v)) begin
      ctl = 8'b0011_0100;
      n.stall = sat_inc(m.stall, cmax);
    end else begin
      ctl = {4'b1111, v.br, 3'b000};
      if (v.br) n.flush = sat_inc(m.flush, cmax);
      if (v.mul && lat > 1) n.hold = lat - 1;
    end
  endfunction

  // One clock cycle: drive, sample at the falling edge, advance models.
  task automatic run_cycle(input in_t v, input bit chk0, output logic [7:0] c0,
                           output int s0, output int f0);
    logic [7:0] e0, e1;
    mdl_t n0, n1;
    drv = v;
    @(negedge clk);
    c0 = ctl0();
    s0 = int'(bus0.stall_cnt);
    f0 = int'(bus0.flush_cnt);
    predict(m0, v, 3, 65535, e0, n0);
    predict(m1, v, 1, 15, e1, n1);
    if (chk0) begin
      check("m0_ctl", int'(c0), int'(e0));
      check("m0_stall", s0, m0.stall);
      check("m0_flush", f0, m0.flush);
    end
    check("m1_ctl", int'(ctl1()), int'(e1));
    check("m1_stall", int'(bus1.stall_cnt), m1.stall);
    check("m1_flush", int'(bus1.flush_cnt), m1.flush);
    m0 = n0;
    m1 = n1;
    @(posedge clk);
    #1;
  endtask

  // Assert reset in the middle of a cycle and confirm outputs drop at once.
  task automatic mid_reset(input string tag);
    drv = mi(0,0,0,0,0,0,0,0,0);
    #2;
    reset_n = 1'b0;
    #1;
    check({tag, "_ctl0"}, int'(ctl0()), 0);
    check({tag, "_ctl1"}, int'(ctl1()), 0);
    check({tag, "_stall0"}, int'(bus0.stall_cnt), 0);
    check({tag, "_flush0"}, int'(bus0.flush_cnt), 0);
    check({tag, "_stall1"}, int'(bus1.stall_cnt), 0);
    m0 = '{0, 0, 0};
    m1 = '{0, 0, 0};
    @(negedge clk);
    check({tag, "_held_ctl0"}, int'(ctl0()), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[22];

  initial begin
    logic [7:0] c;
    int s, f;
    in_t v;

    tbl[0]  = '{mi(0,0,0,0,0,0,0,0,0),   8'hF0, 0, 0};   // idle after reset
    tbl[1]  = '{mi(5,0,1,0,0,1,5,0,0),   8'h34, 0, 0};   // load-use on Rn
    tbl[2]  = '{mi(0,0,0,0,0,0,0,0,0),   8'hF0, 1, 0};
    tbl[3]  = '{mi(0,31,0,1,0,1,31,0,0), 8'hF0, 1, 0};   // XZR never hazards
    tbl[4]  = '{mi(7,7,0,1,0,1,7,0,0),   8'h34, 1, 0};   // load-use on Rm
    tbl[5]  = '{mi(9,0,0,0,0,1,9,0,0),   8'hF0, 2, 0};   // match but unused
    tbl[6]  = '{mi(0,0,0,0,0,0,0,1,0),   8'hF8, 2, 0};   // taken branch
    tbl[7]  = '{mi(3,0,1,0,0,1,3,1,0),   8'h34, 2, 1};   // lu beats branch
    tbl[8]  = '{mi(0,0,0,0,0,0,0,0,0),   8'hF0, 3, 1};
    tbl[9]  = '{mi(0,0,0,0,1,0,0,0,0),   8'hF0, 3, 1};   // MUL enters hold
    tbl[10] = '{mi(0,0,0,0,0,0,0,0,0),   8'h13, 3, 1};
    tbl[11] = '{mi(3,0,1,0,0,1,3,1,0),   8'h13, 4, 1};   // lu/br ignored
    tbl[12] = '{mi(0,0,0,0,0,0,0,0,0),   8'hF0, 5, 1};
    tbl[13] = '{mi(0,0,0,0,1,0,0,1,0),   8'hF8, 5, 1};   // MUL with branch
    tbl[14] = '{mi(0,0,0,0,0,0,0,0,0),   8'h13, 5, 2};
    tbl[15] = '{mi(0,0,0,0,0,0,0,0,1),   8'h01, 6, 2};   // freeze in hold
    tbl[16] = '{mi(0,0,0,0,0,0,0,0,1),   8'h01, 7, 2};
    tbl[17] = '{mi(0,0,0,0,0,0,0,0,1),   8'h01, 8, 2};
    tbl[18] = '{mi(0,0,0,0,0,0,0,0,0),   8'h13, 9, 2};   // last hold cycle
    tbl[19] = '{mi(0,0,0,0,0,0,0,0,0),   8'hF0, 10, 2};
    tbl[20] = '{mi(4,0,1,0,1,1,4,1,1),   8'h00, 10, 2};  // freeze beats all
    tbl[21] = '{mi(0,0,0,0,0,0,0,0,0),   8'hF0, 11, 2};  // no MUL taken

    m0 = '{0, 0, 0};
    m1 = '{0, 0, 0};
    drv = mi(0,0,0,0,0,0,0,0,0);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_ctl0", int'(ctl0()), 0);
    check("rst_stall0", int'(bus0.stall_cnt), 0);
    check("rst_flush0", int'(bus0.flush_cnt), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 22; k++) begin
      run_cycle(tbl[k].i, 1'b0, c, s, f);
      check($sformatf("vec%0d_ctl", k), int'(c), int'(tbl[k].ctl));
      check($sformatf("vec%0d_stall", k), s, tbl[k].stall);
      check($sformatf("vec%0d_flush", k), f, tbl[k].flush);
      $display("vec %0d ctl=%02h stall=%0d flush=%0d", k, c, s, f);
    end

    // Counter saturation on the 4-bit instance
    mid_reset("rst_a");
    for (int k = 0; k < 20; k++) run_cycle(mi(2,0,1,0,0,1,2,0,0), 1'b1, c, s, f);
    check("sat_stall1", int'(bus1.stall_cnt), 15);
    check("sat_stall0", int'(bus0.stall_cnt), 20);
    for (int k = 0; k < 20; k++) run_cycle(mi(0,0,0,0,0,0,0,1,0), 1'b1, c, s, f);
    check("sat_flush1", int'(bus1.flush_cnt), 15);
    check("sat_flush0", int'(bus0.flush_cnt), 20);
    $display("saturation stall1=%0d flush1=%0d", bus1.stall_cnt, bus1.flush_cnt);

    // Reset while dut0 is in MUL_HOLD
    run_cycle(mi(0,0,0,0,1,0,0,0,0), 1'b1, c, s, f);
    run_cycle(mi(0,0,0,0,0,0,0,0,0), 1'b1, c, s, f);
    check("pre_rst_busy", int'(bus0.busy), 1);
    mid_reset("rst_b");
    run_cycle(mi(0,0,0,0,0,0,0,0,0), 1'b1, c, s, f);
    check("post_rst_run", int'(c), 8'hF0);
    $display("reset mid-hold ctl=%02h stall=%0d", c, s);

    // Randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      v.rd     = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      v.rn     = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      v.rm     = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      v.use_rn = 1'($urandom_range(0, 1));
      v.use_rm = 1'($urandom_range(0, 1));
      v.mrd    = 1'($urandom_range(0, 1));
      v.mul    = ($urandom_range(0, 5) == 0);
      v.br     = ($urandom_range(0, 3) == 0);
      v.dw     = ($urandom_range(0, 7) == 0);
      run_cycle(v, 1'b1, c, s, f);
    end
    $display("random done ctl=%02h stall=%0d flush=%0d", c, s, f);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
